psum_result_collector: RTL and testbench

- Downstream of the 16-lane PE cube stage. Captures one tile of 16 per-lane results: the 21-bit strategy-1 results or the 32-bit strategy-2 results.
- Optionally applies ReLU to the captured results.
- Holds them in a two-bank ping-pong buffer, then drains each tile as 128-bit beats over a valid/ready stream toward the output SRAM writer.
- Upstream sees a single "buffer full" flag it must honour. A drop counter and a sticky overflow flag report lost tiles.

---
 rtl/psum_result_collector_pkg.sv | 36 +++
 rtl/psum_result_collector_bank.sv | 55 +++++
 rtl/psum_result_collector.sv | 161 ++++++++++++++++
 tb/tb_psum_result_collector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_result_collector_pkg.sv
// Shared parameters, state encodings and lane formatting for the psum result collector.
package psum_result_collector_pkg;

  localparam int NUM_LANES      = 16;
  localparam int LANE_W         = 32;
  localparam int S1_W           = 21;
  localparam int BEAT_LANES     = 4;
  localparam int BEATS_PER_TILE = NUM_LANES / BEAT_LANES;
  localparam int BEAT_W         = BEAT_LANES * LANE_W;
  localparam int TILE_W         = NUM_LANES * LANE_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drain_state_e;

  // Select strategy lane, sign-extend strategy-1 values, then optionally clamp negatives.
  function automatic logic [LANE_W-1:0] fmt_lane(
    input logic              s2_en,
    input logic [S1_W-1:0]   s1,
    input logic [LANE_W-1:0] s2,
    input logic              relu_en
  );
    logic [LANE_W-1:0] v;
    if (s2_en) begin
      v = s2;
    end else begin
      v = {{(LANE_W-S1_W){s1[S1_W-1]}}, s1};
    end
    if (relu_en && v[LANE_W-1]) begin
      v = {LANE_W{1'b0}};
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/psum_result_collector_bank.sv
// One ping-pong bank: 16 lane registers, an occupancy flag and a 4:1 beat read mux.
module psum_bank
  import psum_result_collector_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cap_i,
  input  logic              free_i,
  input  logic [1:0]        beat_i,
  input  logic [TILE_W-1:0] lanes_i,
  output logic              full_o,
  output logic [BEAT_W-1:0] beat_data_o
);

  logic [LANE_W-1:0] lanes_q [NUM_LANES];
  bank_state_e       state_q, state_d;

  // Lane storage, written as a whole tile on capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_LANES; n++) lanes_q[n] <= {LANE_W{1'b0}};
    end else if (cap_i) begin
      for (int n = 0; n < NUM_LANES; n++) lanes_q[n] <= lanes_i[n*LANE_W +: LANE_W];
    end
  end

  // Occupancy next state; the top never captures and frees the same bank in one cycle.
  always_comb begin
    state_d = state_q;
    if (cap_i) begin
      state_d = FULL;
    end else if (free_i) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Beat mux: lane 4*beat+j lands at slot j.
  always_comb begin
    beat_data_o = {BEAT_W{1'b0}};
    for (int j = 0; j < BEAT_LANES; j++) begin
      beat_data_o[j*LANE_W +: LANE_W] = lanes_q[{beat_i, 2'(j)}];
    end
  end

  assign full_o = (state_q == FULL);

endmodule

// File: rtl/psum_result_collector.sv
// Captures 16-lane PE results into a two-bank ping-pong buffer and drains each tile as four 128-bit beats.
module psum_result_collector
  import psum_result_collector_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_result_valid,
  input  logic         i_strategy_2_en,
  input  logic [335:0] i_result_s1,
  input  logic [511:0] i_result_s2,
  input  logic         i_relu_en,
  input  logic         i_clr_overflow,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic [1:0]   o_beat_idx,
  output logic         o_last,
  output logic         o_overflow,
  output logic [7:0]   o_drop_cnt
);

  logic [TILE_W-1:0] fmt_lanes_s;
  logic [BEAT_W-1:0] bank_data_s [2];
  logic [1:0]        bank_full_s, cap_s, free_s, occ_next_s;
  logic              accept_s, drop_s, fire_s, last_fire_s;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        beat_q, beat_d;
  logic              full_q, full_d, overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  drain_state_e      state_q, state_d;

  // Per-lane mode select, sign extension and ReLU.
  always_comb begin
    fmt_lanes_s = {TILE_W{1'b0}};
    for (int n = 0; n < NUM_LANES; n++) begin
      fmt_lanes_s[n*LANE_W +: LANE_W] = fmt_lane(i_strategy_2_en, i_result_s1[n*S1_W +: S1_W],
                                                 i_result_s2[n*LANE_W +: LANE_W], i_relu_en);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    psum_bank u_bank (
      .clk_i       (i_clk),
      .rst_n_i     (i_rst_n),
      .cap_i       (cap_s[b]),
      .free_i      (free_s[b]),
      .beat_i      (beat_q),
      .lanes_i     (fmt_lanes_s),
      .full_o      (bank_full_s[b]),
      .beat_data_o (bank_data_s[b])
    );
  end

  // Capture/drop decisions and pointer/beat bookkeeping, all from start-of-cycle bank state.
  always_comb begin
    accept_s    = i_result_valid && !bank_full_s[wr_ptr_q];
    drop_s      = i_result_valid &&  bank_full_s[wr_ptr_q];
    cap_s       = 2'b00;
    cap_s[wr_ptr_q] = accept_s;
    fire_s      = (state_q == DRAIN) && i_ready;
    last_fire_s = fire_s && (beat_q == 2'd3);
    free_s      = 2'b00;
    free_s[rd_ptr_q] = last_fire_s;
    occ_next_s  = cap_s | (bank_full_s & ~free_s);
    full_d      = &occ_next_s;
    wr_ptr_d    = accept_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_d      = beat_q;
    if (last_fire_s) begin
      rd_ptr_d = ~rd_ptr_q;
      beat_d   = 2'd0;
    end else if (fire_s) begin
      beat_d   = beat_q + 2'd1;
    end else begin
      beat_d   = beat_q;
    end
  end

  // Drop wins over a coincident clear so the lost tile is still reported.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (i_clr_overflow) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (i_clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Drain next state; a capture landing this cycle counts as ready so beats start with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bank_full_s[rd_ptr_q] || cap_s[rd_ptr_q]) state_d = DRAIN;
        else                                          state_d = IDLE;
      end
      DRAIN: begin
        if (last_fire_s) begin
          if (bank_full_s[~rd_ptr_q] || cap_s[~rd_ptr_q]) state_d = DRAIN;
          else                                            state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pointers, beat counter and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_q     <= 2'd0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    o_valid    = (state_q == DRAIN);
    o_beat_idx = beat_q;
    o_last     = (state_q == DRAIN) && (beat_q == 2'd3);
    if (state_q == DRAIN) begin
      o_data = bank_data_s[rd_ptr_q];
    end else begin
      o_data = {BEAT_W{1'b0}};
    end
    o_full     = full_q;
    o_overflow = overflow_q;
    o_drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_psum_result_collector.sv
// Scoreboard bench for psum_result_collector: expected beats queued at stimulus, checked on handshake.
module tb_psum_result_collector;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_result_valid = 1'b0;
  logic         i_strategy_2_en = 1'b0;
  logic [335:0] i_result_s1 = '0;
  logic [511:0] i_result_s2 = '0;
  logic         i_relu_en = 1'b0;
  logic         i_clr_overflow = 1'b0;
  logic         i_ready = 1'b0;
  logic         o_full, o_valid, o_last, o_overflow;
  logic [127:0] o_data;
  logic [1:0]   o_beat_idx;
  logic [7:0]   o_drop_cnt;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  beat_t sb_q[$];
  beat_t mon_b;
  int    n_total = 0;
  int    n_bad   = 0;

  psum_result_collector dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_result_valid(i_result_valid),
    .i_strategy_2_en(i_strategy_2_en), .i_result_s1(i_result_s1), .i_result_s2(i_result_s2),
    .i_relu_en(i_relu_en), .i_clr_overflow(i_clr_overflow), .o_full(o_full),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_beat_idx(o_beat_idx),
    .o_last(o_last), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lane(input logic s2en, input logic relu,
                                           input logic [20:0] a, input logic [31:0] b);
    logic [31:0] v;
    v = s2en ? b : {{11{a[20]}}, a};
    if (relu && v[31]) v = 32'd0;
    return v;
  endfunction

  task automatic push_tile(input logic s2en, input logic relu,
                           input logic [335:0] s1, input logic [511:0] s2);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++)
        b.data[32*j +: 32] = ref_lane(s2en, relu, s1[21*(4*k+j) +: 21], s2[32*(4*k+j) +: 32]);
      b.idx  = 2'(k);
      b.last = (k == 3);
      sb_q.push_back(b);
    end
  endtask

  function automatic logic [511:0] rand_s2();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [335:0] rand_s1();
    logic [335:0] v;
    for (int i = 0; i < 16; i++) v[21*i +: 21] = 21'($urandom);
    return v;
  endfunction

  // One-cycle result pulse; caller states whether the tile should be accepted.
  task automatic send(input logic s2en, input logic relu, input logic [335:0] s1,
                      input logic [511:0] s2, input bit accept);
    i_result_valid  = 1'b1;
    i_strategy_2_en = s2en;
    i_relu_en       = relu;
    i_result_s1     = s1;
    i_result_s2     = s2;
    if (accept) push_tile(s2en, relu, s1, s2);
    @(posedge i_clk); #1;
    i_result_valid  = 1'b0;
    i_strategy_2_en = 1'($urandom);
    i_relu_en       = 1'($urandom);
    i_result_s1     = rand_s1();
    i_result_s2     = rand_s2();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (sb_q.size() != 0 && c < 60) begin @(negedge i_clk); c++; end
    check_val(tag, 128'(sb_q.size()), 128'd0);
    @(negedge i_clk);
    check_val({tag, "_idle"}, 128'(o_valid), 128'd0);
  endtask

  // Handshake monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        check_val("extra_beat", 128'(o_valid), 128'd0);
      end else begin
        mon_b = sb_q.pop_front();
        check_val("beat_data", o_data, mon_b.data);
        check_val("beat_idx", 128'(o_beat_idx), 128'(mon_b.idx));
        check_val("beat_last", 128'(o_last), 128'(mon_b.last));
      end
    end
  end

  initial begin
    logic [511:0] s2v;
    logic [335:0] s1v;
    logic [127:0] hold;
    int c;

    #1;
    check_val("rst_valid", 128'(o_valid), 128'd0);
    check_val("rst_data", o_data, 128'd0);
    check_val("rst_idx", 128'(o_beat_idx), 128'd0);
    check_val("rst_last", 128'(o_last), 128'd0);
    check_val("rst_full", 128'(o_full), 128'd0);
    check_val("rst_ovf", 128'(o_overflow), 128'd0);
    check_val("rst_cnt", 128'(o_drop_cnt), 128'd0);
    cycles(2);
    i_rst_n = 1'b1;
    cycles(1);

    // Strategy-2 ramp, ready high.
    i_ready = 1'b1;
    for (int n = 0; n < 16; n++) s2v[32*n +: 32] = 32'(n) * 32'h01010101;
    send(1'b1, 1'b0, rand_s1(), s2v, 1'b1);
    @(negedge i_clk);
    check_val("t1_latency", 128'(o_valid), 128'd1);
    check_val("t1_beat0", o_data, {32'h03030303, 32'h02020202, 32'h01010101, 32'h00000000});
    wait_drain("t1_drain");

    // Strategy-1 with and without ReLU.
    for (int r = 1; r >= 0; r--) begin
      s1v = rand_s1();
      s1v[20:0]  = 21'h1FFFFF;
      s1v[41:21] = 21'h0FFFFF;
      cycles(1);
      send(1'b0, 1'(r), s1v, rand_s2(), 1'b1);
      @(negedge i_clk);
      check_val("t2_lane0", 128'(o_data[31:0]), (r == 1) ? 128'h0 : 128'hFFFFFFFF);
      check_val("t2_lane1", 128'(o_data[63:32]), 128'h000FFFFF);
      wait_drain("t2_drain");
    end

    // Backpressure hold.
    i_ready = 1'b0;
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    hold = sb_q[0].data;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check_val("t3_hold_valid", 128'(o_valid), 128'd1);
      check_val("t3_hold_data", o_data, hold);
      check_val("t3_hold_idx", 128'(o_beat_idx), 128'd0);
    end
    cycles(1);
    i_ready = 1'b1;
    wait_drain("t3_drain");

    // Overflow: two captures fill both banks, third is dropped.
    i_ready = 1'b0;
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    cycles(3);
    send(1'b0, 1'b1, rand_s1(), rand_s2(), 1'b1);
    @(negedge i_clk);
    check_val("t4_full", 128'(o_full), 128'd1);
    cycles(3);
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b0);
    @(negedge i_clk);
    check_val("t4_ovf", 128'(o_overflow), 128'd1);
    check_val("t4_cnt", 128'(o_drop_cnt), 128'd1);
    check_val("t4_full_kept", 128'(o_full), 128'd1);
    cycles(1);
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      check_val("t4_no_bubble", 128'(o_valid), 128'd1);
    end
    @(negedge i_clk);
    check_val("t4_end_valid", 128'(o_valid), 128'd0);
    check_val("t4_end_full", 128'(o_full), 128'd0);
    check_val("t4_sb_empty", 128'(sb_q.size()), 128'd0);

    // Capture on the same cycle as the final beat handshake.
    cycles(1);
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    cycles(3);
    check_val("t5_at_last", 128'(o_last), 128'd1);
    send(1'b0, 1'b0, rand_s1(), rand_s2(), 1'b1);
    @(negedge i_clk);
    check_val("t5_cont_valid", 128'(o_valid), 128'd1);
    check_val("t5_cont_idx", 128'(o_beat_idx), 128'd0);
    check_val("t5_no_drop", 128'(o_drop_cnt), 128'd1);
    wait_drain("t5_drain");

    // Clear coinciding with a drop.
    i_ready = 1'b0;
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    send(1'b1, 1'b1, rand_s1(), rand_s2(), 1'b1);
    send(1'b0, 1'b0, rand_s1(), rand_s2(), 1'b0);
    @(negedge i_clk);
    check_val("t5_cnt2", 128'(o_drop_cnt), 128'd2);
    cycles(1);
    i_clr_overflow = 1'b1;
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b0);
    i_clr_overflow = 1'b0;
    @(negedge i_clk);
    check_val("t5_clr_drop_cnt", 128'(o_drop_cnt), 128'd1);
    check_val("t5_clr_drop_ovf", 128'(o_overflow), 128'd1);
    cycles(1);
    i_clr_overflow = 1'b1;
    cycles(1);
    i_clr_overflow = 1'b0;
    check_val("t5_clr_cnt", 128'(o_drop_cnt), 128'd0);
    check_val("t5_clr_ovf", 128'(o_overflow), 128'd0);
    i_ready = 1'b1;
    wait_drain("t5b_drain");

    // Async reset in the middle of a drain.
    i_ready = 1'b0;
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b1);
    send(1'b1, 1'b0, rand_s1(), rand_s2(), 1'b0);
    cycles(1);
    i_ready = 1'b1;
    c = 0;
    do begin @(negedge i_clk); c++; end while (o_beat_idx != 2'd2 && c < 20);
    check_val("t6_reach_beat2", 128'(o_beat_idx), 128'd2);
    i_rst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", 128'(o_valid), 128'd0);
    check_val("t6_rst_full", 128'(o_full), 128'd0);
    check_val("t6_rst_ovf", 128'(o_overflow), 128'd0);
    check_val("t6_rst_cnt", 128'(o_drop_cnt), 128'd0);
    sb_q.delete();
    cycles(2);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_val("t6_no_residual", 128'(o_valid), 128'd0);
    end
    cycles(1);
    send(1'b0, 1'b0, rand_s1(), rand_s2(), 1'b1);
    @(negedge i_clk);
    check_val("t6_new_valid", 128'(o_valid), 128'd1);
    check_val("t6_new_idx", 128'(o_beat_idx), 128'd0);
    wait_drain("t6_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
